// File: rtl/execute_unit_pkg.sv
// ----------------------------------------------------------------------------
// execute_unit_pkg
// Shared definitions for the RV32I execute stage: opcode constants, the
// 4-bit ALU select encoding, writeback-select and memory-size encodings,
// and the special instruction words (bubble marker, reset NOP).
// No ports (package).
// ----------------------------------------------------------------------------
package execute_unit_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_sel_e;

    typedef enum logic [1:0] {
        WB_MEM = 2'd0,
        WB_ALU = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    localparam logic [31:0] INST_BUBBLE = 32'hffffffff;
    localparam logic [31:0] INST_NOP    = 32'h00000013;

endpackage

// File: rtl/execute_unit_alu.sv
// ----------------------------------------------------------------------------
// exec_alu
// Purely combinational 32-bit ALU for the execute stage. Shifts use the low
// five bits of operand B; arithmetic wraps modulo 2^32.
// Ports:
//   i_a    in  32  operand A
//   i_b    in  32  operand B
//   i_sel  in  4   ALU select (alu_sel_e encoding)
//   o_res  out 32  result
// ----------------------------------------------------------------------------
module exec_alu
    import execute_unit_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_sel,
    output logic [31:0] o_res
);

    logic signed [31:0] w_a_s;
    logic signed [31:0] w_b_s;
    logic        [4:0]  w_shamt;

    assign w_a_s   = i_a;
    assign w_b_s   = i_b;
    assign w_shamt = i_b[4:0];

    always_comb begin
        o_res = 32'd0;
        case (i_sel)
            ALU_ADD:    o_res = i_a + i_b;
            ALU_SUB:    o_res = i_a - i_b;
            ALU_SLL:    o_res = i_a << w_shamt;
            ALU_SLT:    o_res = (w_a_s < w_b_s) ? 32'd1 : 32'd0;
            ALU_SLTU:   o_res = (i_a < i_b) ? 32'd1 : 32'd0;
            ALU_XOR:    o_res = i_a ^ i_b;
            ALU_SRL:    o_res = i_a >> w_shamt;
            ALU_SRA:    o_res = w_a_s >>> w_shamt;
            ALU_OR:     o_res = i_a | i_b;
            ALU_AND:    o_res = i_a & i_b;
            ALU_PASS_B: o_res = i_b;
            default:    o_res = 32'd0;
        endcase
    end

endmodule

// File: rtl/execute_unit.sv
// ----------------------------------------------------------------------------
// execute_unit
// RV32I execute stage between the D/X and X/M pipeline registers. Decodes the
// instruction in X, compares the (already forwarded) register operands for
// branches, computes the ALU result / branch target, raises the fetch
// redirect, and registers results and controls into X/M.
// Optional feature macro: EXEC_ILLEGAL_TRAP_EN -- when defined, a
// non-bubble unrecognised opcode raises illegal_m for one cycle; when
// undefined, illegal_m is tied 0.
// Ports:
//   clock, reset               rising-edge clock, sync active-high reset
//   inst_x, pc_x               instruction in X (all-ones = bubble) and its PC
//   rs1_x, rs2_x, imm_x        forwarded operands and sign-extended immediate
//   pc_sel, alu_res            combinational redirect and ALU result/target
//   br_eq, br_lt               combinational compare flags
//   alu_m, rs2_m, pc_m, inst_m X/M data registers
//   rd_m, reg_wen_m, wb_sel_m  writeback controls
//   mem_rw_m, mem_size_m,
//   mem_sign_m                 memory controls
//   illegal_m                  illegal-instruction flag
// ----------------------------------------------------------------------------
module execute_unit
    import execute_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inst_x,
    input  logic [31:0] pc_x,
    input  logic [31:0] rs1_x,
    input  logic [31:0] rs2_x,
    input  logic [31:0] imm_x,
    output logic        pc_sel,
    output logic [31:0] alu_res,
    output logic        br_eq,
    output logic        br_lt,
    output logic [31:0] alu_m,
    output logic [31:0] rs2_m,
    output logic [31:0] pc_m,
    output logic [31:0] inst_m,
    output logic [4:0]  rd_m,
    output logic        reg_wen_m,
    output logic [1:0]  wb_sel_m,
    output logic        mem_rw_m,
    output logic [1:0]  mem_size_m,
    output logic        mem_sign_m,
    output logic        illegal_m
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_alt;          // funct7[5]: SUB / SRA / SRAI
    logic [3:0]  w_alu_sel;
    logic        w_a_pc;
    logic        w_b_rs2;
    logic        w_reg_wen;
    logic [1:0]  w_wb_sel;
    logic        w_mem_rw;
    logic [1:0]  w_mem_size;
    logic        w_mem_sign;
    logic        w_is_jump;
    logic        w_is_jalr;
    logic        w_is_branch;
    logic        w_taken;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [31:0] w_alu_out;
    logic signed [31:0] w_rs1_s;
    logic signed [31:0] w_rs2_s;
`ifdef EXEC_ILLEGAL_TRAP_EN
    logic        w_illegal;
    logic        r_illegal_m;
`endif

    assign w_opcode = inst_x[6:0];
    assign w_funct3 = inst_x[14:12];
    assign w_alt    = inst_x[30];

    // OP-IMM/OP share one funct3 decode; only OP honours SUB, both honour SRA.
    function automatic logic [3:0] arith_sel(input logic [2:0] f3,
                                             input logic       alt,
                                             input logic       is_reg);
        logic [3:0] sel;
        case (f3)
            3'b000:  sel = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLTU;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            default: sel = ALU_AND;
        endcase
        return sel;
    endfunction

    always_comb begin
        w_alu_sel   = ALU_ADD;
        w_a_pc      = 1'b0;
        w_b_rs2     = 1'b0;
        w_reg_wen   = 1'b0;
        w_wb_sel    = WB_ALU;
        w_mem_rw    = 1'b0;
        w_mem_size  = MEM_BYTE;
        w_mem_sign  = 1'b0;
        w_is_jump   = 1'b0;
        w_is_jalr   = 1'b0;
        w_is_branch = 1'b0;
`ifdef EXEC_ILLEGAL_TRAP_EN
        w_illegal   = 1'b0;
`endif
        case (w_opcode)
            OPC_LUI: begin
                w_alu_sel = ALU_PASS_B;
                w_reg_wen = 1'b1;
            end
            OPC_AUIPC: begin
                w_a_pc    = 1'b1;
                w_reg_wen = 1'b1;
            end
            OPC_JAL: begin
                w_a_pc    = 1'b1;
                w_reg_wen = 1'b1;
                w_wb_sel  = WB_PC4;
                w_is_jump = 1'b1;
            end
            OPC_JALR: begin
                w_reg_wen = 1'b1;
                w_wb_sel  = WB_PC4;
                w_is_jump = 1'b1;
                w_is_jalr = 1'b1;
            end
            OPC_BRANCH: begin
                w_a_pc      = 1'b1;
                w_is_branch = 1'b1;
            end
            OPC_LOAD: begin
                w_reg_wen  = 1'b1;
                w_wb_sel   = WB_MEM;
                w_mem_size = w_funct3[1:0];
                w_mem_sign = ~w_funct3[2];
            end
            OPC_STORE: begin
                w_mem_rw   = 1'b1;
                w_mem_size = w_funct3[1:0];
                w_mem_sign = ~w_funct3[2];
            end
            OPC_OPIMM: begin
                w_alu_sel = arith_sel(w_funct3, w_alt, 1'b0);
                w_reg_wen = 1'b1;
            end
            OPC_OP: begin
                w_alu_sel = arith_sel(w_funct3, w_alt, 1'b1);
                w_b_rs2   = 1'b1;
                w_reg_wen = 1'b1;
            end
            default: begin
`ifdef EXEC_ILLEGAL_TRAP_EN
                w_illegal = (inst_x != INST_BUBBLE);
`endif
            end
        endcase
    end

    // Branch compare: funct3[1] selects unsigned (BLTU/BGEU).
    assign w_rs1_s = rs1_x;
    assign w_rs2_s = rs2_x;
    assign br_eq   = (rs1_x == rs2_x);
    assign br_lt   = w_funct3[1] ? (rs1_x < rs2_x) : (w_rs1_s < w_rs2_s);

    always_comb begin
        case (w_funct3)
            3'b000:         w_taken = br_eq;
            3'b001:         w_taken = ~br_eq;
            3'b100, 3'b110: w_taken = br_lt;
            3'b101, 3'b111: w_taken = ~br_lt;
            default:        w_taken = 1'b0;
        endcase
    end

    assign pc_sel = w_is_jump | (w_is_branch & w_taken);

    assign w_op_a = w_a_pc  ? pc_x  : rs1_x;
    assign w_op_b = w_b_rs2 ? rs2_x : imm_x;

    exec_alu u_alu (
        .i_a   (w_op_a),
        .i_b   (w_op_b),
        .i_sel (w_alu_sel),
        .o_res (w_alu_out)
    );

    // JALR target drops bit 0.
    assign alu_res = w_is_jalr ? {w_alu_out[31:1], 1'b0} : w_alu_out;

    // ---- X/M stage boundary ----
    always_ff @(posedge clock) begin
        if (reset) begin
            alu_m      <= 32'd0;
            rs2_m      <= 32'd0;
            pc_m       <= 32'd0;
            inst_m     <= INST_NOP;
            rd_m       <= 5'd0;
            reg_wen_m  <= 1'b0;
            wb_sel_m   <= 2'd0;
            mem_rw_m   <= 1'b0;
            mem_size_m <= 2'd0;
            mem_sign_m <= 1'b0;
        end else begin
            alu_m      <= alu_res;
            rs2_m      <= rs2_x;
            pc_m       <= pc_x;
            inst_m     <= inst_x;
            rd_m       <= inst_x[11:7];
            reg_wen_m  <= w_reg_wen;
            wb_sel_m   <= w_wb_sel;
            mem_rw_m   <= w_mem_rw;
            mem_size_m <= w_mem_size;
            mem_sign_m <= w_mem_sign;
        end
    end

`ifdef EXEC_ILLEGAL_TRAP_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_illegal_m <= 1'b0;
        end else begin
            r_illegal_m <= w_illegal;
        end
    end
    assign illegal_m = r_illegal_m;
`else
    assign illegal_m = 1'b0;
`endif

endmodule

// File: tb/tb_execute_unit.sv
module tb_execute_unit;

    logic        clock;
    logic        reset;
    logic [31:0] inst_x, pc_x, rs1_x, rs2_x, imm_x;
    logic        pc_sel, br_eq, br_lt;
    logic [31:0] alu_res, alu_m, rs2_m, pc_m, inst_m;
    logic [4:0]  rd_m;
    logic        reg_wen_m, mem_rw_m, mem_sign_m, illegal_m;
    logic [1:0]  wb_sel_m, mem_size_m;

    int total = 0;
    int bad   = 0;

    execute_unit dut (
        .clock      (clock),
        .reset      (reset),
        .inst_x     (inst_x),
        .pc_x       (pc_x),
        .rs1_x      (rs1_x),
        .rs2_x      (rs2_x),
        .imm_x      (imm_x),
        .pc_sel     (pc_sel),
        .alu_res    (alu_res),
        .br_eq      (br_eq),
        .br_lt      (br_lt),
        .alu_m      (alu_m),
        .rs2_m      (rs2_m),
        .pc_m       (pc_m),
        .inst_m     (inst_m),
        .rd_m       (rd_m),
        .reg_wen_m  (reg_wen_m),
        .wb_sel_m   (wb_sel_m),
        .mem_rw_m   (mem_rw_m),
        .mem_size_m (mem_size_m),
        .mem_sign_m (mem_sign_m),
        .illegal_m  (illegal_m)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6f, JALR = 7'h67,
                           BR = 7'h63, LD = 7'h03, ST = 7'h23, OPI = 7'h13, OP = 7'h33;

    typedef struct {
        logic        alu_known;
        logic [31:0] alu;
        logic        pc_sel;
        logic        eq;
        logic        lt;
        logic        wen;
        logic [1:0]  wb;
        logic        is_mem;
        logic        rw;
        logic [1:0]  size;
        logic        sign;
        logic        ill;
    } exp_t;

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, r2, r1, f3, rd, op};
    endfunction

    // Architectural meaning of an RV32I register/immediate operation.
    function automatic logic [31:0] arith(input logic [2:0] f3, input logic sub_or_sra,
                                          input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (f3)
            3'd0: return sub_or_sra ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 1 : 0;
            3'd3: return (a < b) ? 1 : 0;
            3'd4: return a ^ b;
            3'd5: return sub_or_sra ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] imm);
        exp_t e;
        logic [2:0] f3;
        logic known;
        f3 = inst[14:12];
        e.alu_known = 1; e.alu = 0; e.pc_sel = 0; e.wen = 0; e.wb = 1;
        e.is_mem = 0; e.rw = 0; e.size = 0; e.sign = 0; e.ill = 0;
        e.eq = (a == b);
        e.lt = f3[1] ? (a < b) : ($signed(a) < $signed(b));
        known = 1;
        case (inst[6:0])
            LUI:   begin e.alu = imm; e.wen = 1; end
            AUIPC: begin e.alu = pc + imm; e.wen = 1; end
            JAL:   begin e.alu = pc + imm; e.wen = 1; e.wb = 2; e.pc_sel = 1; end
            JALR:  begin e.alu = (a + imm) & 32'hffff_fffe; e.wen = 1; e.wb = 2; e.pc_sel = 1; end
            BR: begin
                e.alu = pc + imm;
                if (f3 == 0)                 e.pc_sel = (a == b);
                else if (f3 == 1)            e.pc_sel = (a != b);
                else if (f3 == 4)            e.pc_sel = ($signed(a) <  $signed(b));
                else if (f3 == 5)            e.pc_sel = ($signed(a) >= $signed(b));
                else if (f3 == 6)            e.pc_sel = (a <  b);
                else if (f3 == 7)            e.pc_sel = (a >= b);
            end
            LD: begin e.alu = a + imm; e.wen = 1; e.wb = 0; e.is_mem = 1;
                      e.size = f3[1:0]; e.sign = !f3[2]; end
            ST: begin e.alu = a + imm; e.rw = 1; e.is_mem = 1;
                      e.size = f3[1:0]; e.sign = !f3[2]; end
            OPI: begin e.alu = arith(f3, (f3 == 5) && inst[30], a, imm); e.wen = 1; end
            OP:  begin e.alu = arith(f3, inst[30], a, b); e.wen = 1; end
            default: begin e.alu_known = 0; known = 0; end
        endcase
`ifdef EXEC_ILLEGAL_TRAP_EN
        e.ill = !known && (inst != 32'hffffffff);
`else
        e.ill = 0;
`endif
        return e;
    endfunction

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
        inst_x = inst; pc_x = pc; rs1_x = a; rs2_x = b; imm_x = imm;
    endtask

    task automatic test_reset;
        reset = 1;
        drive(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OP), 32'h44, 32'd5, 32'd7, 32'd0);
        @(posedge clock); #1;
        total++; if (inst_m !== 32'h13) begin bad++; $display("FAIL rst_inst got=%h exp=%h", inst_m, 32'h13); end
        total++; if (alu_m !== 0) begin bad++; $display("FAIL rst_alu got=%h exp=0", alu_m); end
        total++; if ({pc_m, rs2_m} !== 64'd0) begin bad++; $display("FAIL rst_pc_rs2 got=%h/%h exp=0", pc_m, rs2_m); end
        total++; if ({rd_m, wb_sel_m, mem_size_m} !== 9'd0) begin bad++; $display("FAIL rst_fields got=%h exp=0", {rd_m, wb_sel_m, mem_size_m}); end
        total++; if ({reg_wen_m, mem_rw_m, mem_sign_m, illegal_m} !== 4'd0) begin bad++; $display("FAIL rst_en got=%b exp=0000", {reg_wen_m, mem_rw_m, mem_sign_m, illegal_m}); end
        reset = 0;
    endtask

    task automatic test_alu;
        drive(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OP), 32'h100, 32'd5, 32'd7, 32'd0);
        #1;
        total++; if (alu_res !== 32'd12) begin bad++; $display("FAIL add_res got=%h exp=%h", alu_res, 32'd12); end
        total++; if (pc_sel !== 1'b0) begin bad++; $display("FAIL add_pcsel got=%b exp=0", pc_sel); end
        @(posedge clock); #1;
        total++; if ({reg_wen_m, wb_sel_m} !== 3'b101) begin bad++; $display("FAIL add_ctl got=%b exp=101", {reg_wen_m, wb_sel_m}); end
        total++; if (alu_m !== 32'd12) begin bad++; $display("FAIL add_alum got=%h exp=%h", alu_m, 32'd12); end
        total++; if (rd_m !== 5'd3) begin bad++; $display("FAIL add_rd got=%0d exp=3", rd_m); end
        drive(enc(7'h20, 5'd2, 5'd1, 3'd5, 5'd4, OP), 32'h104, 32'h80000000, 32'd4, 32'd0);
        #1;
        total++; if (alu_res !== 32'hf8000000) begin bad++; $display("FAIL sra got=%h exp=%h", alu_res, 32'hf8000000); end
        drive(enc(7'h00, 5'd2, 5'd1, 3'd5, 5'd4, OP), 32'h108, 32'h80000000, 32'd4, 32'd0);
        #1;
        total++; if (alu_res !== 32'h08000000) begin bad++; $display("FAIL srl got=%h exp=%h", alu_res, 32'h08000000); end
        @(posedge clock); #1;
    endtask

    task automatic test_branch;
        drive(enc(7'h00, 5'd2, 5'd1, 3'd4, 5'd8, BR), 32'h01000010, 32'hffffffff, 32'd1, 32'd8);
        #1;
        total++; if ({br_lt, pc_sel} !== 2'b11) begin bad++; $display("FAIL blt_flags got=%b exp=11", {br_lt, pc_sel}); end
        total++; if (alu_res !== 32'h01000018) begin bad++; $display("FAIL blt_target got=%h exp=%h", alu_res, 32'h01000018); end
        drive(enc(7'h00, 5'd2, 5'd1, 3'd6, 5'd8, BR), 32'h01000010, 32'hffffffff, 32'd1, 32'd8);
        #1;
        total++; if ({br_lt, pc_sel} !== 2'b00) begin bad++; $display("FAIL bltu_flags got=%b exp=00", {br_lt, pc_sel}); end
        @(posedge clock); #1;
        total++; if ({reg_wen_m, mem_rw_m} !== 2'b00) begin bad++; $display("FAIL br_en got=%b exp=00", {reg_wen_m, mem_rw_m}); end
    endtask

    task automatic test_jalr;
        drive(enc(7'h00, 5'd0, 5'd1, 3'd0, 5'd1, JALR), 32'h200, 32'h01000101, 32'd0, 32'd0);
        #1;
        total++; if (alu_res !== 32'h01000100) begin bad++; $display("FAIL jalr_target got=%h exp=%h", alu_res, 32'h01000100); end
        total++; if (pc_sel !== 1'b1) begin bad++; $display("FAIL jalr_pcsel got=%b exp=1", pc_sel); end
        @(posedge clock); #1;
        total++; if ({wb_sel_m, reg_wen_m} !== 3'b101) begin bad++; $display("FAIL jalr_ctl got=%b exp=101", {wb_sel_m, reg_wen_m}); end
    endtask

    task automatic test_mem;
        drive(enc(7'h7f, 5'd30, 5'd1, 3'd1, 5'd5, LD), 32'h300, 32'h100, 32'd0, 32'hfffffffe);
        #1;
        total++; if (alu_res !== 32'hfe) begin bad++; $display("FAIL lh_addr got=%h exp=%h", alu_res, 32'hfe); end
        @(posedge clock); #1;
        total++; if ({mem_size_m, mem_sign_m, mem_rw_m} !== 4'b0110) begin bad++; $display("FAIL lh_ctl got=%b exp=0110", {mem_size_m, mem_sign_m, mem_rw_m}); end
        drive(enc(7'h00, 5'd2, 5'd1, 3'd2, 5'd4, ST), 32'h304, 32'h100, 32'hcafef00d, 32'd4);
        @(posedge clock); #1;
        total++; if ({mem_rw_m, mem_size_m, reg_wen_m} !== 4'b1100) begin bad++; $display("FAIL sw_ctl got=%b exp=1100", {mem_rw_m, mem_size_m, reg_wen_m}); end
        total++; if (rs2_m !== 32'hcafef00d) begin bad++; $display("FAIL sw_data got=%h exp=%h", rs2_m, 32'hcafef00d); end
    endtask

    task automatic test_reset_during_store;
        reset = 1;
        drive(enc(7'h00, 5'd2, 5'd1, 3'd2, 5'd4, ST), 32'h400, 32'h100, 32'h55, 32'd4);
        @(posedge clock); #1;
        total++; if ({reg_wen_m, mem_rw_m, mem_sign_m, illegal_m} !== 4'd0) begin bad++; $display("FAIL rst_sw_en got=%b exp=0000", {reg_wen_m, mem_rw_m, mem_sign_m, illegal_m}); end
        total++; if (inst_m !== 32'h13) begin bad++; $display("FAIL rst_sw_inst got=%h exp=%h", inst_m, 32'h13); end
        drive(32'hffffffff, 32'h404, 32'd1, 32'd1, 32'd0);
        #1;
        total++; if (pc_sel !== 1'b0) begin bad++; $display("FAIL rst_bubble_pcsel got=%b exp=0", pc_sel); end
        @(posedge clock); #1;
        reset = 0;
    endtask

    task automatic test_bubble;
        drive(32'hffffffff, 32'h500, 32'd3, 32'd3, 32'd0);
        #1;
        total++; if (pc_sel !== 1'b0) begin bad++; $display("FAIL bubble_pcsel got=%b exp=0", pc_sel); end
        @(posedge clock); #1;
        total++; if ({reg_wen_m, mem_rw_m, illegal_m} !== 3'd0) begin bad++; $display("FAIL bubble_en got=%b exp=000", {reg_wen_m, mem_rw_m, illegal_m}); end
        total++; if (inst_m !== 32'hffffffff) begin bad++; $display("FAIL bubble_inst got=%h exp=ffffffff", inst_m); end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] pool [6];
        pool[0] = $urandom; pool[1] = 0; pool[2] = 1;
        pool[3] = 32'h80000000; pool[4] = 32'h7fffffff; pool[5] = 32'hffffffff;
        return ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
    endfunction

    // Random back-to-back instruction stream, every cycle checked against the model.
    task automatic test_back_to_back(input int n);
        logic [2:0] br_f3 [6];
        logic [2:0] ld_f3 [5];
        br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < n; i++) begin
            logic [31:0] inst, pc, a, b, imm;
            logic [6:0]  f7;
            logic [2:0]  f3;
            exp_t e;
            f3 = 3'($urandom);
            f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            pc = $urandom & 32'hffff_fffc;
            a = pick_operand();
            b = ($urandom_range(0, 3) == 0) ? a : pick_operand();
            imm = $urandom;
            case ($urandom_range(0, 10))
                0: inst = enc(7'($urandom), 5'($urandom), 5'($urandom), f3, 5'($urandom), LUI);
                1: inst = enc(7'($urandom), 5'($urandom), 5'($urandom), f3, 5'($urandom), AUIPC);
                2: inst = enc(7'($urandom), 5'($urandom), 5'($urandom), f3, 5'($urandom), JAL);
                3: inst = enc(7'($urandom), 5'($urandom), 5'($urandom), 3'd0, 5'($urandom), JALR);
                4: inst = enc(7'($urandom), 5'($urandom), 5'($urandom), br_f3[$urandom_range(0, 5)], 5'($urandom), BR);
                5: inst = enc(7'($urandom), 5'($urandom), 5'($urandom), ld_f3[$urandom_range(0, 4)], 5'($urandom), LD);
                6: inst = enc(7'($urandom), 5'($urandom), 5'($urandom), 3'($urandom_range(0, 2)), 5'($urandom), ST);
                7: inst = enc((f3 == 3'd5) ? f7 : 7'($urandom), 5'($urandom), 5'($urandom), f3, 5'($urandom), OPI);
                8: inst = enc((f3 == 3'd0 || f3 == 3'd5) ? f7 : 7'h00, 5'($urandom), 5'($urandom), f3, 5'($urandom), OP);
                9: inst = 32'hffffffff;
                default: inst = enc(7'($urandom), 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'h0b);
            endcase
            e = model(inst, pc, a, b, imm);
            drive(inst, pc, a, b, imm);
            #1;
            total++; if ({br_eq, br_lt} !== {e.eq, e.lt}) begin bad++; $display("FAIL rnd_cmp[%0d] got=%b exp=%b inst=%h", i, {br_eq, br_lt}, {e.eq, e.lt}, inst); end
            total++; if (pc_sel !== e.pc_sel) begin bad++; $display("FAIL rnd_pcsel[%0d] got=%b exp=%b inst=%h", i, pc_sel, e.pc_sel, inst); end
            if (e.alu_known) begin
                total++; if (alu_res !== e.alu) begin bad++; $display("FAIL rnd_alu[%0d] got=%h exp=%h inst=%h", i, alu_res, e.alu, inst); end
            end
            @(posedge clock); #1;
            if (e.alu_known) begin
                total++; if (alu_m !== e.alu) begin bad++; $display("FAIL rnd_alum[%0d] got=%h exp=%h", i, alu_m, e.alu); end
            end
            total++; if ({inst_m, pc_m, rs2_m, rd_m} !== {inst, pc, b, inst[11:7]}) begin bad++; $display("FAIL rnd_data[%0d] got=%h/%h/%h/%0d exp=%h/%h/%h/%0d", i, inst_m, pc_m, rs2_m, rd_m, inst, pc, b, inst[11:7]); end
            total++; if ({reg_wen_m, mem_rw_m, illegal_m} !== {e.wen, e.rw, e.ill}) begin bad++; $display("FAIL rnd_en[%0d] got=%b exp=%b inst=%h", i, {reg_wen_m, mem_rw_m, illegal_m}, {e.wen, e.rw, e.ill}, inst); end
            if (e.alu_known) begin
                total++; if (wb_sel_m !== e.wb) begin bad++; $display("FAIL rnd_wb[%0d] got=%0d exp=%0d", i, wb_sel_m, e.wb); end
            end
            if (e.is_mem) begin
                total++; if ({mem_size_m, mem_sign_m} !== {e.size, e.sign}) begin bad++; $display("FAIL rnd_mem[%0d] got=%b exp=%b", i, {mem_size_m, mem_sign_m}, {e.size, e.sign}); end
            end
        end
    endtask

    initial begin
        reset = 1;
        drive(32'hffffffff, 0, 0, 0, 0);
        @(posedge clock); #1;
        test_reset();
        test_alu();
        test_branch();
        test_jalr();
        test_mem();
        test_reset_during_store();
        test_bubble();
        test_back_to_back(400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
